// File: rtl/cmd_byte_assembler_pkg.sv
// Shared types and constants for the command byte assembler.
// CMD_PARITY_EN adds the S_PAR state to the assembly FSM.
package cmd_asm_pkg;

  localparam int GAP_W = 4;

  typedef enum logic [2:0] {
    S_OP   = 3'd0,
    S_ADDR = 3'd1,
    S_DHI  = 3'd2,
`ifdef CMD_PARITY_EN
    S_DLO  = 3'd3,
    S_PAR  = 3'd4
`else
    S_DLO  = 3'd3
`endif
  } state_t;

  typedef struct packed {
    logic [7:0]  op_code;
    logic [7:0]  address;
    logic [15:0] data;
  } cmd_t;

  localparam logic [7:0]  CMD_RST_OP   = 8'hff;
  localparam logic [7:0]  CMD_RST_ADDR = 8'hff;
  localparam logic [15:0] CMD_RST_DATA = 16'hffff;

  localparam cmd_t CMD_RST = '{
    op_code: CMD_RST_OP,
    address: CMD_RST_ADDR,
    data:    CMD_RST_DATA
  };

  function automatic logic [7:0] cmd_parity(cmd_t c);
    return c.op_code ^ c.address ^ c.data[15:8] ^ c.data[7:0];
  endfunction

endpackage

// File: rtl/cmd_byte_assembler_if.sv
// Byte-stream input and command-strobe output bundle.
// master = assembler side, slave = feeder/consumer side.
interface cmd_byte_assembler_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          in_valid;
  logic [7:0]    in_byte;
  logic          in_ready;
  logic          hold;
  logic          enable;
  logic [7:0]    op_code;
  logic [7:0]    address;
  logic [15:0]   data;
  logic [CW-1:0] fifo_count;
  logic          busy;
  logic          err;

  modport master (
    input  in_valid, in_byte, hold,
    output in_ready, enable, op_code, address, data,
    output fifo_count, busy, err
  );

  modport slave (
    output in_valid, in_byte, hold,
    input  in_ready, enable, op_code, address, data,
    input  fifo_count, busy, err
  );

endinterface

// File: rtl/cmd_byte_assembler_fifo.sv
// Command FIFO: power-of-2 depth, registered count, async reset.
// Head entry is readable combinationally while non-empty.
module cmd_fifo
  import cmd_asm_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  cmd_t          push_data,
  input  logic          pop,
  output cmd_t          pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;
  cmd_t          mem_q [DEPTH];

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Pointer and occupancy update
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/cmd_byte_assembler.sv
// Assembles op/addr/dhi/dlo bytes into commands, queues them, issues strobes.
// CMD_PARITY_EN: trailing XOR parity byte; bad parity drops cmd, pulses err.
module cmd_byte_assembler
  import cmd_asm_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_GAP    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  cmd_byte_assembler_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t     state_q, state_d;
  logic [7:0] op_q, op_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] dhi_q, dhi_d;
`ifdef CMD_PARITY_EN
  logic [7:0] dlo_q, dlo_d;
  logic       err_q, err_d;
`endif

  logic             accept, push, pop;
  logic             full, empty;
  logic [CW-1:0]    count;
  cmd_t             push_cmd, head;
  cmd_t             out_q, out_d;
  logic             en_q, en_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  assign accept = bus.in_valid && !full;

  // Assembly state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_OP;
    else       state_q <= state_d;
  end

  // Next assembly state; moves only when a byte is taken
  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (state_q)
        S_OP:    state_d = S_ADDR;
        S_ADDR:  state_d = S_DHI;
        S_DHI:   state_d = S_DLO;
`ifdef CMD_PARITY_EN
        S_DLO:   state_d = S_PAR;
        S_PAR:   state_d = S_OP;
`else
        S_DLO:   state_d = S_OP;
`endif
        default: state_d = S_OP;
      endcase
    end
  end

  // Byte capture, push decision and parity check per state
  always_comb begin
    op_d   = op_q;
    addr_d = addr_q;
    dhi_d  = dhi_q;
    push   = 1'b0;
`ifdef CMD_PARITY_EN
    dlo_d    = dlo_q;
    err_d    = 1'b0;
    push_cmd = '{op_code: op_q, address: addr_q,
                 data: {dhi_q, dlo_q}};
`else
    push_cmd = '{op_code: op_q, address: addr_q,
                 data: {dhi_q, bus.in_byte}};
`endif
    if (accept) begin
      unique case (state_q)
        S_OP:    op_d   = bus.in_byte;
        S_ADDR:  addr_d = bus.in_byte;
        S_DHI:   dhi_d  = bus.in_byte;
`ifdef CMD_PARITY_EN
        S_DLO:   dlo_d  = bus.in_byte;
        S_PAR: begin
          if (bus.in_byte == cmd_parity(push_cmd)) push  = 1'b1;
          else                                     err_d = 1'b1;
        end
`else
        S_DLO:   push   = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  // Partial-command byte registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= '0;
      addr_q <= '0;
      dhi_q  <= '0;
`ifdef CMD_PARITY_EN
      dlo_q  <= '0;
      err_q  <= 1'b0;
`endif
    end else begin
      op_q   <= op_d;
      addr_q <= addr_d;
      dhi_q  <= dhi_d;
`ifdef CMD_PARITY_EN
      dlo_q  <= dlo_d;
      err_q  <= err_d;
`endif
    end
  end

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_cmd),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Issue: pop when allowed, strobe one cycle, then enforce the gap
  always_comb begin
    pop   = !empty && !bus.hold && (gap_q == '0);
    en_d  = pop;
    out_d = pop ? head : out_q;
    if (pop)                gap_d = GAP_W'(MIN_GAP);
    else if (gap_q != '0)   gap_d = gap_q - 1'b1;
    else                    gap_d = gap_q;
  end

  // Issue registers; fields reset to the downstream reset image
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= CMD_RST;
      en_q  <= 1'b0;
      gap_q <= '0;
    end else begin
      out_q <= out_d;
      en_q  <= en_d;
      gap_q <= gap_d;
    end
  end

  assign bus.in_ready   = !full;
  assign bus.enable     = en_q;
  assign bus.op_code    = out_q.op_code;
  assign bus.address    = out_q.address;
  assign bus.data       = out_q.data;
  assign bus.fifo_count = count;
  assign bus.busy       = (state_q != S_OP) || !empty;
`ifdef CMD_PARITY_EN
  assign bus.err        = err_q;
`else
  assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_byte_assembler.sv
// Bench for cmd_byte_assembler: two instances (MIN_GAP 0 and 2).
// Reference model groups accepted bytes into expected commands.
module tb_cmd_byte_assembler;
  import cmd_asm_pkg::*;

  localparam int DEPTH = 4;
`ifdef CMD_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  typedef struct packed {
    longint t;
    cmd_t   c;
  } pulse_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  pulse_t     pq[2][$];
  cmd_t       expq[2][$];
  logic [7:0] bbuf[2][$];
  longint     errq[$];
  longint     last_acc[2];
  int         exp_err = 0;

  always #5 clk = ~clk;

  cmd_byte_assembler_if #(.FIFO_DEPTH(DEPTH)) bus0 ();
  cmd_byte_assembler_if #(.FIFO_DEPTH(DEPTH)) bus1 ();

  cmd_byte_assembler #(.FIFO_DEPTH(DEPTH), .MIN_GAP(0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  cmd_byte_assembler #(.FIFO_DEPTH(DEPTH), .MIN_GAP(2)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  // Record every strobe and every err pulse with its sample time
  always @(negedge clk) begin
    if (bus0.enable === 1'b1)
      pq[0].push_back({longint'($time), bus0.op_code, bus0.address, bus0.data});
    if (bus1.enable === 1'b1)
      pq[1].push_back({longint'($time), bus1.op_code, bus1.address, bus1.data});
    if (bus0.err === 1'b1 || bus1.err === 1'b1)
      errq.push_back(longint'($time));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(int w, logic v, logic [7:0] b);
    if (w == 0) begin bus0.in_valid = v; bus0.in_byte = b; end
    else        begin bus1.in_valid = v; bus1.in_byte = b; end
  endtask

  task automatic set_hold(int w, logic h);
    if (w == 0) bus0.hold = h;
    else        bus1.hold = h;
  endtask

  function automatic logic rdy(int w);
    return (w == 0) ? bus0.in_ready : bus1.in_ready;
  endfunction

  function automatic logic [7:0] cmd_byte(cmd_t c, int j);
    logic [7:0] bs [5];
    bs[0] = c.op_code;
    bs[1] = c.address;
    bs[2] = c.data[15:8];
    bs[3] = c.data[7:0];
    bs[4] = bs[0] ^ bs[1] ^ bs[2] ^ bs[3];
    return bs[j];
  endfunction

  // Reference model: every NB accepted bytes form one command
  task automatic model_byte(int w, logic [7:0] b);
    cmd_t c;
    bbuf[w].push_back(b);
    last_acc[w] = longint'($time);
    if (bbuf[w].size() == NB) begin
      c = {bbuf[w][0], bbuf[w][1], bbuf[w][2], bbuf[w][3]};
`ifdef CMD_PARITY_EN
      if ((bbuf[w][0] ^ bbuf[w][1] ^ bbuf[w][2] ^ bbuf[w][3]) == bbuf[w][4])
        expq[w].push_back(c);
      else
        exp_err++;
`else
      expq[w].push_back(c);
`endif
      bbuf[w].delete();
    end
  endtask

  task automatic send(int w, logic [7:0] b);
    bit ok = 1'b0;
    set_in(w, 1'b1, b);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rdy(w) === 1'b1) begin ok = 1'b1; break; end
    end
    chk("send_ready", 64'(ok), 64'd1);
    if (ok) begin
      @(posedge clk);
      model_byte(w, b);
      #1;
    end
  endtask

  task automatic idle(int w);
    set_in(w, 1'b0, 8'h00);
  endtask

  task automatic wait_cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(int w, cmd_t c, bit gaps);
    for (int j = 0; j < NB; j++) begin
      send(w, cmd_byte(c, j));
      if (gaps && $urandom_range(0, 2) == 0) begin
        idle(w);
        wait_cyc(1);
      end
    end
    idle(w);
  endtask

  task automatic drain(int w, string tag);
    pulse_t p;
    cmd_t   c;
    chk({tag, "_npulse"}, 64'(pq[w].size()), 64'(expq[w].size()));
    while (pq[w].size() > 0 && expq[w].size() > 0) begin
      p = pq[w].pop_front();
      c = expq[w].pop_front();
      chk(tag, 64'(p.c), 64'(c));
    end
    pq[w].delete();
    expq[w].delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int w = 0; w < 2; w++) begin
      pq[w].delete();
      expq[w].delete();
      bbuf[w].delete();
    end
  endtask

  initial begin
    cmd_t   c;
    longint t0;
    idle(0); idle(1);
    set_hold(0, 1'b0); set_hold(1, 1'b0);

    // Reset image
    do_reset();
    @(negedge clk);
    chk("rst_enable", 64'(bus0.enable), 64'd0);
    chk("rst_op", 64'(bus0.op_code), 64'hff);
    chk("rst_addr", 64'(bus0.address), 64'hff);
    chk("rst_data", 64'(bus0.data), 64'hffff);
    chk("rst_ready", 64'(bus0.in_ready), 64'd1);
    chk("rst_count", 64'(bus0.fifo_count), 64'd0);
    chk("rst_busy", 64'(bus0.busy), 64'd0);
    chk("rst_err", 64'(bus0.err), 64'd0);
    chk("rst1_data", 64'(bus1.data), 64'hffff);
    wait_cyc(1);

    // Single command, latency and hold-after
    send_cmd(0, {8'h01, 8'h10, 16'habcd}, 1'b0);
    t0 = last_acc[0];
    wait_cyc(5);
    if (pq[0].size() > 0)
      chk("lat_time", 64'(pq[0][0].t), 64'(t0 + 15));
    drain(0, "single");
    @(negedge clk);
    chk("held_en", 64'(bus0.enable), 64'd0);
    chk("held_op", 64'(bus0.op_code), 64'h01);
    chk("held_addr", 64'(bus0.address), 64'h10);
    chk("held_data", 64'(bus0.data), 64'habcd);
    chk("idle_busy", 64'(bus0.busy), 64'd0);
    wait_cyc(1);

    // Hold fills the FIFO, back-pressure, then drain at full rate
    set_hold(0, 1'b1);
    for (int k = 0; k < 4; k++) send_cmd(0, cmd_t'($urandom), 1'b0);
    @(negedge clk);
    chk("full_count", 64'(bus0.fifo_count), 64'd4);
    chk("full_ready", 64'(bus0.in_ready), 64'd0);
    chk("full_busy", 64'(bus0.busy), 64'd1);
    chk("hold_nopulse", 64'(pq[0].size()), 64'd0);
    c = cmd_t'($urandom);
    set_in(0, 1'b1, cmd_byte(c, 0));
    repeat (3) @(negedge clk);
    chk("full_ready_wait", 64'(bus0.in_ready), 64'd0);
    chk("full_count_wait", 64'(bus0.fifo_count), 64'd4);
    @(posedge clk);
    #1;
    set_hold(0, 1'b0);
    send_cmd(0, c, 1'b0);
    wait_cyc(6);
    if (pq[0].size() >= 4) begin
      chk("burst_sp1", 64'(pq[0][1].t - pq[0][0].t), 64'd10);
      chk("burst_sp3", 64'(pq[0][3].t - pq[0][0].t), 64'd30);
    end
    drain(0, "burst");

    // Push and pop on the same edge keep the count
    set_hold(0, 1'b1);
    send_cmd(0, cmd_t'($urandom), 1'b0);
    send_cmd(0, cmd_t'($urandom), 1'b0);
    c = cmd_t'($urandom);
    for (int j = 0; j < NB - 1; j++) send(0, cmd_byte(c, j));
    set_hold(0, 1'b0);
    send(0, cmd_byte(c, NB - 1));
    idle(0);
    @(negedge clk);
    chk("pushpop_count", 64'(bus0.fifo_count), 64'd2);
    chk("pushpop_en", 64'(bus0.enable), 64'd1);
    wait_cyc(5);
    drain(0, "pushpop");

    // MIN_GAP = 2 instance: pulses 3 cycles apart
    set_hold(1, 1'b1);
    for (int k = 0; k < 3; k++) send_cmd(1, cmd_t'($urandom), 1'b0);
    set_hold(1, 1'b0);
    wait_cyc(12);
    if (pq[1].size() >= 3) begin
      chk("gap_sp01", 64'(pq[1][1].t - pq[1][0].t), 64'd30);
      chk("gap_sp12", 64'(pq[1][2].t - pq[1][1].t), 64'd30);
    end
    drain(1, "gap");

    // Reset mid-command discards partial bytes and queued commands
    set_hold(0, 1'b1);
    send_cmd(0, cmd_t'($urandom), 1'b0);
    send(0, 8'h22);
    send(0, 8'h33);
    idle(0);
    do_reset();
    @(negedge clk);
    chk("mid_rst_count", 64'(bus0.fifo_count), 64'd0);
    chk("mid_rst_busy", 64'(bus0.busy), 64'd0);
    chk("mid_rst_op", 64'(bus0.op_code), 64'hff);
    set_hold(0, 1'b0);
    wait_cyc(1);
    send_cmd(0, {8'h05, 8'h06, 16'h0708}, 1'b0);
    wait_cyc(5);
    drain(0, "after_rst");

`ifdef CMD_PARITY_EN
    // Parity good then bad
    send(0, 8'h01); send(0, 8'h02); send(0, 8'h03);
    send(0, 8'h04); send(0, 8'h04);
    idle(0);
    wait_cyc(5);
    drain(0, "par_ok");
    send(0, 8'h01); send(0, 8'h02); send(0, 8'h03);
    send(0, 8'h04); send(0, 8'hff);
    idle(0);
    t0 = last_acc[0];
    @(negedge clk);
    chk("par_err_hi", 64'(bus0.err), 64'd1);
    chk("par_count", 64'(bus0.fifo_count), 64'd0);
    wait_cyc(4);
    chk("par_err_n", 64'(errq.size()), 64'(exp_err));
    if (errq.size() > 0)
      chk("par_err_t", 64'(errq[errq.size() - 1]), 64'(t0 + 5));
    drain(0, "par_bad");
`endif

    // Randomized stream with random hold and byte gaps
    for (int k = 0; k < 30; k++) begin
      set_hold(0, (k % 4 != 3) && ($urandom_range(0, 1) == 1));
      send_cmd(0, cmd_t'($urandom), 1'b1);
    end
    set_hold(0, 1'b0);
    wait_cyc(20);
    drain(0, "rand");
    @(negedge clk);
    chk("rand_count", 64'(bus0.fifo_count), 64'd0);
    chk("rand_busy", 64'(bus0.busy), 64'd0);
    chk("err_total", 64'(errq.size()), 64'(exp_err));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
